tdm_demux_4ch: RTL and testbench

- Receive side of the 4-channel TDM link fed by the team's 4:1 selector: one shared data line carries channel 0..3 in successive slots.
- Recovers slot position from a frame sync strobe and routes each slot to its channel.
- Presents all four channels together, registered and updated atomically once per frame, with a frame-valid pulse and a sticky sync-error flag.
- Sits between the serial link input and the per-channel consumers.

---
 rtl/tdm_demux_4ch.sv | 120 ++++++++++++
 tb/tb_tdm_demux_4ch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4-channel TDM link: locks on frame sync, routes slots to channels, publishes whole frames.
// Optional macro TDM_CHK_EN: 5-slot frames whose last slot carries the XOR of slots 0..3.
module tdm_demux_4ch #(
  parameter int DATA_W = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [DATA_W-1:0]   Ent,
  input  logic                Sync,
  input  logic                En,
  output logic [4*DATA_W-1:0] Sal,
  output logic [2:0]          Sel,
  output logic                Val,
  output logic                Err
);

`ifdef TDM_CHK_EN
  localparam int SEL_W = 3;
  localparam int NSH   = 4;
`else
  localparam int SEL_W = 2;
  localparam int NSH   = 3;
`endif
  // Index of the slot that completes a frame.
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NSH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [DATA_W-1:0]   shadow_reg [NSH];
  logic                shadow_we;
  logic [1:0]          shadow_idx;
  logic [4*DATA_W-1:0] sal_reg, sal_next;
  logic [4*DATA_W-1:0] frame_word;
  logic                val_reg, val_next;
  logic                err_reg, err_next;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pack
      assign frame_word[gi*DATA_W +: DATA_W] = shadow_reg[gi];
    end
  endgenerate

`ifdef TDM_CHK_EN
  logic check_ok;
  assign frame_word[3*DATA_W +: DATA_W] = shadow_reg[3];
  assign check_ok = (Ent == (shadow_reg[0] ^ shadow_reg[1] ^ shadow_reg[2] ^ shadow_reg[3]));
`else
  // Slot 3 goes straight from the line into the published frame.
  assign frame_word[3*DATA_W +: DATA_W] = Ent;
`endif

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    sal_next   = sal_reg;
    val_next   = 1'b0;
    err_next   = err_reg;
    shadow_we  = 1'b0;
    shadow_idx = 2'd0;
    if (En) begin
      if (Sync) begin
        // Sync anywhere but slot 0 while locked drops the partial frame and restarts.
        if (state_reg == RUN && sel_reg != '0) err_next = 1'b1;
        shadow_we  = 1'b1;
        shadow_idx = 2'd0;
        sel_next   = SEL_W'(1);
        state_next = RUN;
      end else if (state_reg == RUN) begin
        if (sel_reg == '0) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (sel_reg == LAST) begin
          sel_next = '0;
`ifdef TDM_CHK_EN
          if (check_ok) begin
            sal_next = frame_word;
            val_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
`else
          sal_next = frame_word;
          val_next = 1'b1;
`endif
        end else begin
          shadow_we  = 1'b1;
          shadow_idx = sel_reg[1:0];
          sel_next   = sel_reg + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      sal_reg   <= '0;
      val_reg   <= 1'b0;
      err_reg   <= 1'b0;
      for (int i = 0; i < NSH; i++) shadow_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      sal_reg   <= sal_next;
      val_reg   <= val_next;
      err_reg   <= err_next;
      if (shadow_we) shadow_reg[shadow_idx] <= Ent;
    end
  end

  assign Sal = sal_reg;
  assign Sel = 3'(sel_reg);
  assign Val = val_reg;
  assign Err = err_reg;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: frame-level reference model plus directed literal checks.
module tb_tdm_demux_4ch;
`ifdef TDM_CHK_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [0:0] Ent = '0;
  logic       Sync = 1'b0;
  logic       En = 1'b0;
  logic [3:0] Sal;
  logic [2:0] Sel;
  logic       Val;
  logic       Err;

  tdm_demux_4ch #(.DATA_W(1)) dut (
    .Clk(Clk), .Rst(Rst), .Ent(Ent), .Sync(Sync), .En(En),
    .Sal(Sal), .Sel(Sel), .Val(Val), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: collects the slots of the current frame in a queue.
  logic       m_locked = 1'b0;
  logic [0:0] m_frame[$];
  logic [3:0] m_sal = '0;
  logic       m_val = 1'b0;
  logic       m_err = 1'b0;

  always @(posedge Clk) begin
    cyc++;
    if (Rst) begin
      m_locked = 1'b0;
      m_frame.delete();
      m_sal = '0;
      m_val = 1'b0;
      m_err = 1'b0;
    end else begin
      m_val = 1'b0;
      if (En) begin
        if (!m_locked) begin
          if (Sync) begin
            m_frame = {Ent};
            m_locked = 1'b1;
          end
        end else if (Sync) begin
          if (m_frame.size() != 0) m_err = 1'b1;
          m_frame = {Ent};
        end else if (m_frame.size() == 0) begin
          m_err = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_frame.push_back(Ent);
          if (m_frame.size() == NSLOT) begin
`ifdef TDM_CHK_EN
            if (m_frame[4] != (m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3])) m_err = 1'b1;
            else begin
              m_sal = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
              m_val = 1'b1;
            end
`else
            m_sal = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
            m_val = 1'b1;
`endif
            m_frame.delete();
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (mon_en) begin
      check("cyc_sal", 32'(Sal), 32'(m_sal));
      check("cyc_sel", 32'(Sel), 32'(m_frame.size()));
      check("cyc_val", 32'(Val), 32'(m_val));
      check("cyc_err", 32'(Err), 32'(m_err));
    end
  end

  task automatic slot(input logic s, input logic d);
    En = 1'b1; Sync = s; Ent = d;
    @(posedge Clk); #1;
    En = 1'b0; Sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic do_reset();
    Rst = 1'b1; En = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  // One full frame with sync on slot 0; optional gap cycles after each slot but the last.
  task automatic send_frame(input logic d0, input logic d1, input logic d2, input logic d3, input int gap);
    slot(1'b1, d0); idle(gap);
    slot(1'b0, d1); idle(gap);
    slot(1'b0, d2); idle(gap);
`ifdef TDM_CHK_EN
    slot(1'b0, d3); idle(gap);
    slot(1'b0, d0 ^ d1 ^ d2 ^ d3);
`else
    slot(1'b0, d3);
`endif
  endtask

  int c1, c2;

  initial begin
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_sal", 32'(Sal), 32'h0);
    check("rst_sel", 32'(Sel), 32'h0);
    check("rst_val", 32'(Val), 32'h0);
    check("rst_err", 32'(Err), 32'h0);
    Rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    send_frame(1, 1, 0, 0, 0);
    check("lock_sal", 32'(Sal), 32'h3);
    check("lock_val", 32'(Val), 32'h1);
    check("lock_err", 32'(Err), 32'h0);
    check("lock_sel", 32'(Sel), 32'h0);
    idle(1);
    check("lock_val_drop", 32'(Val), 32'h0);

    send_frame(1, 1, 0, 1, 0);
    c1 = cyc;
    check("b2b_sal1", 32'(Sal), 32'hB);
    send_frame(0, 1, 0, 1, 0);
    c2 = cyc;
    check("b2b_sal2", 32'(Sal), 32'hA);
    check("b2b_spacing", 32'(c2 - c1), 32'(NSLOT));

    slot(1'b1, 0); idle(3);
    slot(1'b0, 1); idle(1);
    check("gap_sel_hold", 32'(Sel), 32'h2);
    check("gap_sal_hold", 32'(Sal), 32'hA);
    idle(2);
    slot(1'b0, 1); idle(3);
`ifdef TDM_CHK_EN
    slot(1'b0, 1); idle(3);
    slot(1'b0, 1);
`else
    slot(1'b0, 1);
`endif
    check("gap_sal", 32'(Sal), 32'hE);
    check("gap_val", 32'(Val), 32'h1);

    slot(1'b0, 1);
    check("miss_err", 32'(Err), 32'h1);
    check("miss_sel", 32'(Sel), 32'h0);
    check("miss_sal", 32'(Sal), 32'hE);
    slot(1'b0, 1); slot(1'b0, 0);
    check("miss_ignored_sel", 32'(Sel), 32'h0);
    send_frame(1, 0, 1, 0, 0);
    check("relock_sal", 32'(Sal), 32'h5);

    slot(1'b1, 1); slot(1'b0, 1);
    do_reset();
    check("mrst_sal", 32'(Sal), 32'h0);
    check("mrst_sel", 32'(Sel), 32'h0);
    check("mrst_err", 32'(Err), 32'h0);
    check("mrst_val", 32'(Val), 32'h0);
    send_frame(0, 0, 0, 1, 0);
    check("mrst_frame_sal", 32'(Sal), 32'h8);

    slot(1'b1, 1); slot(1'b0, 0); slot(1'b1, 0);
    check("early_err", 32'(Err), 32'h1);
    check("early_val", 32'(Val), 32'h0);
    check("early_sal", 32'(Sal), 32'h8);
    check("early_sel", 32'(Sel), 32'h1);
    slot(1'b0, 0); slot(1'b0, 1);
`ifdef TDM_CHK_EN
    slot(1'b0, 1); slot(1'b0, 0);
`else
    slot(1'b0, 1);
`endif
    check("early_next_sal", 32'(Sal), 32'hC);
    check("early_next_val", 32'(Val), 32'h1);

`ifdef TDM_CHK_EN
    do_reset();
    slot(1'b1, 1); slot(1'b0, 0); slot(1'b0, 1); slot(1'b0, 1); slot(1'b0, 0);
    check("chk_bad_err", 32'(Err), 32'h1);
    check("chk_bad_val", 32'(Val), 32'h0);
    check("chk_bad_sal", 32'(Sal), 32'h0);
    slot(1'b1, 1); slot(1'b0, 0); slot(1'b0, 1); slot(1'b0, 1); slot(1'b0, 1);
    check("chk_good_sal", 32'(Sal), 32'hD);
    check("chk_good_val", 32'(Val), 32'h1);
`endif

    idle(3);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
